// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: emits round keys 0..10 one per accepted handshake.
// Four S-box lookups per cycle derive the next key from the registered current key.

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Forward S-box, byte x lives at bits [8x : 8x+7] with the MSB first.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX_TBL[{in_i, 3'b000} +: 8];
endmodule

module aes_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic [0:127] round_key,
  output logic [3:0]   round_num,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q, state_d;
  logic [0:127] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  w_cur [4];
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  t_w;
  logic [0:127] next_key;
  logic [7:0]   rcon_xt;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign w_cur[gi] = key_q[gi*32 +: 32];
      aes_sbox u_sbox (
        .in_i  (rot_w[31-8*gi -: 8]),
        .out_o (sub_w[31-8*gi -: 8])
      );
    end
  endgenerate

  // RotWord moves byte 0 of w3 to the byte 3 position.
  assign rot_w   = {w_cur[3][23:0], w_cur[3][31:24]};
  assign t_w     = sub_w ^ {rcon_q, 24'h000000};
  assign rcon_xt = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    n0 = w_cur[0] ^ t_w;
    n1 = w_cur[1] ^ n0;
    n2 = w_cur[2] ^ n1;
    n3 = w_cur[3] ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // The done cycle is already IDLE, but a load there must still be ignored.
        if (key_load && !done_q) begin
          key_d   = key_in;
          rnd_d   = 4'd0;
          rcon_d  = 8'h01;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (rnd_q == LAST_RND) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            key_d  = next_key;
            rnd_d  = rnd_q + 4'd1;
            rcon_d = rcon_xt;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= 4'd0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign round_key = key_q;
  assign round_num = rnd_q;
  assign rk_valid  = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: a GF(2^8)-derived key-schedule model checked every cycle,
// plus FIPS-197 literal vectors, backpressure, load-while-busy and async reset scenarios.

module tb_aes_key_expander;
  localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [0:127] key_in = '0;
  logic         key_load = 1'b0;
  logic         rk_ready = 1'b0;
  logic         busy;
  logic [0:127] round_key;
  logic [3:0]   round_num;
  logic         rk_valid;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_key_expander #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_load  (key_load),
    .busy      (busy),
    .round_key (round_key),
    .round_num (round_num),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Field arithmetic: the S-box is derived from inverses plus the affine map.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  logic [7:0] sbox_m [256];

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, r1, r2, r3, r4;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
      sbox_m[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  logic [127:0] exp_keys [11];

  task automatic compute_keys(input logic [0:127] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[i*32 +: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp ^= {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Transaction-level model: phase 0 idle, 1 delivering keys, 2 done pulse.
  int m_phase = 0;
  int m_idx   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_idx   = 0;
    end else begin
      case (m_phase)
        0: if (key_load) begin
             compute_keys(key_in);
             m_idx   = 0;
             m_phase = 1;
           end
        1: if (rk_ready) begin
             if (m_idx == 10) m_phase = 2;
             else m_idx++;
           end
        default: m_phase = 0;
      endcase
    end
  end

  logic [127:0] cap_key [11];
  int cnt_valid = 0;
  int cnt_done  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rk_valid) begin
        cap_key[round_num] = round_key;
        cnt_valid++;
      end
      if (done) cnt_done++;
      case (m_phase)
        1: begin
          chk("run rk_valid", 128'(rk_valid), 128'd1);
          chk("run busy", 128'(busy), 128'd1);
          chk("run done", 128'(done), 128'd0);
          chk("run round_num", 128'(round_num), 128'(m_idx));
          chk("run round_key", round_key, exp_keys[m_idx]);
          if (rk_ready)
            $display("key r%0d %h accepted", round_num, round_key);
        end
        2: begin
          chk("done pulse", 128'(done), 128'd1);
          chk("done rk_valid", 128'(rk_valid), 128'd0);
          chk("done busy", 128'(busy), 128'd0);
          chk("done round_num", 128'(round_num), 128'd10);
          chk("done round_key", round_key, exp_keys[10]);
        end
        default: begin
          chk("idle rk_valid", 128'(rk_valid), 128'd0);
          chk("idle busy", 128'(busy), 128'd0);
          chk("idle done", 128'(done), 128'd0);
        end
      endcase
    end
  end

  bit bp_mode = 1'b0;

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    cnt_valid = 0;
    cnt_done  = 0;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (m_phase != 0 && n < 300) begin
      rk_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (m_phase != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: got phase %0d expected 0", nm, m_phase);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    build_sbox();
    chk("model sbox 00", 128'(sbox_m[8'h00]), 128'h63);
    chk("model sbox 53", 128'(sbox_m[8'h53]), 128'hed);
    compute_keys(A1_KEY);
    chk("model A1 r1", exp_keys[1], A1_R1);
    chk("model A1 r10", exp_keys[10], A1_R10);
    compute_keys('0);
    chk("model zero r1", exp_keys[1], ZERO_R1);

    #12;
    chk("reset round_key", round_key, 128'd0);
    chk("reset round_num", 128'(round_num), 128'd0);
    chk("reset rk_valid", 128'(rk_valid), 128'd0);
    chk("reset busy", 128'(busy), 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 A.1, consumer always ready.
    rk_ready = 1'b1;
    load_key(A1_KEY);
    chk("A1 key0", round_key, A1_KEY);
    wait_idle("A1");
    chk("A1 r1", cap_key[1], A1_R1);
    chk("A1 r10", cap_key[10], A1_R10);
    chk("A1 valid cycles", 128'(cnt_valid), 128'd11);
    chk("A1 done cycles", 128'(cnt_done), 128'd1);
    $display("A1 schedule complete");

    // Zero key.
    load_key('0);
    wait_idle("zero");
    chk("zero r1", cap_key[1], ZERO_R1);
    chk("zero valid cycles", 128'(cnt_valid), 128'd11);

    // Random backpressure on the A.1 key.
    bp_mode = 1'b1;
    load_key(A1_KEY);
    wait_idle("backpressure");
    chk("bp r1", cap_key[1], A1_R1);
    chk("bp r10", cap_key[10], A1_R10);
    chk("bp done cycles", 128'(cnt_done), 128'd1);
    bp_mode = 1'b0;
    rk_ready = 1'b1;

    // key_load held high with another key through busy and the done cycle.
    key_in = A1_KEY; key_load = 1'b1;
    @(posedge clk); #1;
    key_in = '0;
    n = 0;
    while (m_phase != 2 && n < 100) begin @(posedge clk); #1; n++; end
    if (m_phase != 2) begin
      n_cmp++; n_bad++;
      $display("FAIL ldbusy timeout: got phase %0d expected 2", m_phase);
    end
    chk("ldbusy r10", cap_key[10], A1_R10);
    chk("ldbusy r1", cap_key[1], A1_R1);
    @(posedge clk); #1;
    chk("done-cycle load ignored", 128'(busy), 128'd0);
    @(posedge clk); #1;
    key_load = 1'b0;
    chk("reload round_num", 128'(round_num), 128'd0);
    chk("reload key0", round_key, 128'd0);
    chk("reload busy", 128'(busy), 128'd1);
    wait_idle("reload");
    chk("reload r1", cap_key[1], ZERO_R1);

    // Asynchronous reset at round 5, between clock edges.
    load_key(A1_KEY);
    n = 0;
    while (round_num != 4'd5 && n < 20) begin @(posedge clk); #1; n++; end
    chk("pre-reset round_num", 128'(round_num), 128'd5);
    #1 rst = 1'b1;
    #1;
    chk("async rst round_key", round_key, 128'd0);
    chk("async rst round_num", 128'(round_num), 128'd0);
    chk("async rst rk_valid", 128'(rk_valid), 128'd0);
    chk("async rst busy", 128'(busy), 128'd0);
    chk("async rst done", 128'(done), 128'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    load_key(A1_KEY);
    wait_idle("post-reset");
    chk("post-reset r1", cap_key[1], A1_R1);
    chk("post-reset r10", cap_key[10], A1_R10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative AES-128 key schedule (FIPS-197) that generates round keys 0..10 one at a time from a 128-bit cipher key.
- Sits directly upstream of the AddRoundKey stage and drives its round_key input, one key per round, under a valid/ready handshake.
- The round controller is the consumer. It can stall key delivery until the matching state word is ready.

Parameters:
- NUM_ROUNDS, 10, index of the final round key. Only 10 (AES-128) is supported. round_num width is fixed at 4 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  [0:127]  cipher key; bit 0 is MSB of byte 0; word w0 = key_in[0:31].
- key_load  input  1  start request; samples key_in when accepted.
- busy  output  1  high while a schedule is in progress; key_load is ignored while high.
- round_key  output  [0:127]  current round key, same bit/byte ordering as key_in.
- round_num  output  [3:0]  index (0..10) of round_key.
- rk_valid  output  1  round_key/round_num are valid.
- rk_ready  input  1  consumer accepts round_key when rk_valid & rk_ready.
- done  output  1  one-cycle pulse after round key 10 is accepted.

Behaviour:
- Reset (async, any time including mid-schedule):
  - state=IDLE; round_key=0, round_num=0, rk_valid=0, busy=0, done=0.
  - Internal rcon=8'h01.
- FSM states: IDLE, RUN.
- IDLE:
  - On key_load=1, register round_key<=key_in, round_num<=0, rcon<=8'h01, rk_valid<=1, busy<=1, then go to RUN.
  - Latency: key 0 is valid the cycle after key_load.
- RUN:
  - No handshake (rk_ready=0): round_key, round_num and rk_valid hold stable. No change of any output is allowed while stalled.
  - Handshake with round_num<10:
    - round_key<=next key; round_num<=round_num+1; rcon<=xtime(rcon), where xtime = shift left 1, XOR 8'h1B if the MSB was set. The rcon sequence is 01,02,04,08,10,20,40,80,1B,36.
    - rk_valid stays 1, so there are no bubbles.
  - Handshake with round_num==10: rk_valid<=0, busy<=0, done<=1 for exactly one cycle, then go to IDLE. round_key and round_num keep their last values.
- Next-key function, with w0..w3 the current words:
  - t = SubWord(RotWord(w3)) XOR {rcon,24'h0}. RotWord moves byte 0 to byte 3. SubWord applies the FIPS-197 S-box to each byte.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Computed combinationally from registered round_key within one cycle. Four S-box lookups; the existing S-box lookup may be instantiated.
- key_load while busy=1, including the cycle done is asserted: ignored. A new load is accepted only in IDLE, so the earliest is the cycle after done.
- With rk_ready tied high, keys 0..10 appear on 11 consecutive cycles. done is asserted in the cycle after key 10 is accepted. A full schedule takes 12 cycles from key_load.
- rk_valid never drops before key 10 is accepted. round_num never wraps past 10.

Test Plan:
- FIPS-197 A.1, key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - key0 = key_in.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 consecutive valid cycles, then done for 1 cycle, then busy=0.
- Zero key, rk_ready=1: round 1 = 62636363626363636263636362636363. round_num increments 0..10 with no gaps.
- Backpressure: A.1 key, rk_ready toggled pseudo-randomly.
  - Every key value and its round_num must be stable while stalled.
  - The sequence must equal the stall-free run.
  - done occurs only after key 10 is accepted.
- key_load pulsed with a different key while busy, and on the done cycle: ignored, and the output sequence is unchanged. A load one cycle after done starts a fresh schedule with round_num=0.
- rst asserted mid-schedule at round_num=5, asynchronously between edges:
  - All outputs go to 0 immediately and the FSM is in IDLE.
  - A subsequent A.1 load reproduces the A.1 vectors, which proves rcon restarted at 01.
